dsp_be_mlse_tap_pipe: RTL and testbench

DSP_BE_MLSE_TAP_PIPE -- requirements
Module: dsp_be_mlse_tap_pipe

---
 rtl/dsp_be_mlse_tap_pipe.sv | 139 +++++++++++++
 tb/tb_dsp_be_mlse_tap_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_be_mlse_tap_pipe.sv
// MLSE tap pipeline: registers d0/dm1/dm2 pattern flags and dm2 arithmetic results
// per lane, carrying the top two lanes of the previous accepted beat across beats.
package dsp_be_mlse_tap_pipe_pkg;
    typedef struct packed {
        logic p1a;
        logic p1b;
        logic p2;
        logic p3a;
        logic p3b;
        logic p3o;
        logic p4m;
        logic p4p;
    } flag_unit_t;

    typedef struct packed {
        logic [7:0] dpre;
        logic [7:0] dpst;
        logic [7:0] dcomp;
    } ari_unit_t;
endpackage

module dsp_be_mlse_tap_pipe
    import dsp_be_mlse_tap_pipe_pkg::*;
#(
    parameter int unsigned PRLL_RANK = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_vld,
    input  logic                                 i_flush,
    input  flag_unit_t [PRLL_RANK-1:0]           i_flag_unit,
    input  ari_unit_t  [PRLL_RANK-1:0]           i_ari_unit,
    output logic                                 o_vld,
    output flag_unit_t [PRLL_RANK-1:0][2:0]      o_flag_unit_d0m1m2,
    output ari_unit_t  [PRLL_RANK-1:0]           o_ari_unit_dm2,
    output logic                                 o_hist_ok
);

    typedef enum logic {
        COLD = 1'b0,
        WARM = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic accept;

    // hist_*[0] holds lane PRLL_RANK-2, hist_*[1] holds lane PRLL_RANK-1
    flag_unit_t [1:0] hist_flag_q, hist_flag_d;
    ari_unit_t  [1:0] hist_ari_q,  hist_ari_d;

    flag_unit_t [PRLL_RANK-1:0][2:0] tap_flag;
    ari_unit_t  [PRLL_RANK-1:0]      tap_ari;

    flag_unit_t [PRLL_RANK-1:0][2:0] flag_out_q, flag_out_d;
    ari_unit_t  [PRLL_RANK-1:0]      ari_out_q,  ari_out_d;
    logic                            vld_q, vld_d;
    logic                            hist_ok_q, hist_ok_d;

    assign accept = i_vld & ~i_flush;

    for (genvar k = 0; k < PRLL_RANK; k++) begin : g_lane
        assign tap_flag[k][2] = i_flag_unit[k];
        if (k == 0) begin : g_lane0
            assign tap_flag[k][1] = hist_flag_q[1];
            assign tap_flag[k][0] = hist_flag_q[0];
            assign tap_ari[k]     = hist_ari_q[0];
        end else if (k == 1) begin : g_lane1
            assign tap_flag[k][1] = i_flag_unit[0];
            assign tap_flag[k][0] = hist_flag_q[1];
            assign tap_ari[k]     = hist_ari_q[1];
        end else begin : g_lane_n
            assign tap_flag[k][1] = i_flag_unit[k-1];
            assign tap_flag[k][0] = i_flag_unit[k-2];
            assign tap_ari[k]     = i_ari_unit[k-2];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= COLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = COLD;
        end else if (i_vld) begin
            state_d = WARM;
        end
    end

    always_comb begin
        hist_flag_d = hist_flag_q;
        hist_ari_d  = hist_ari_q;
        flag_out_d  = flag_out_q;
        ari_out_d   = ari_out_q;
        vld_d       = accept;
        hist_ok_d   = accept && (state_q == WARM);
        if (i_flush) begin
            hist_flag_d = '0;
            hist_ari_d  = '0;
        end else if (i_vld) begin
            hist_flag_d[0] = i_flag_unit[PRLL_RANK-2];
            hist_flag_d[1] = i_flag_unit[PRLL_RANK-1];
            hist_ari_d[0]  = i_ari_unit[PRLL_RANK-2];
            hist_ari_d[1]  = i_ari_unit[PRLL_RANK-1];
            flag_out_d     = tap_flag;
            ari_out_d      = tap_ari;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_flag_q <= '0;
            hist_ari_q  <= '0;
            flag_out_q  <= '0;
            ari_out_q   <= '0;
            vld_q       <= 1'b0;
            hist_ok_q   <= 1'b0;
        end else begin
            hist_flag_q <= hist_flag_d;
            hist_ari_q  <= hist_ari_d;
            flag_out_q  <= flag_out_d;
            ari_out_q   <= ari_out_d;
            vld_q       <= vld_d;
            hist_ok_q   <= hist_ok_d;
        end
    end

    assign o_vld              = vld_q;
    assign o_hist_ok          = hist_ok_q;
    assign o_flag_unit_d0m1m2 = flag_out_q;
    assign o_ari_unit_dm2     = ari_out_q;

endmodule

// File: tb/tb_dsp_be_mlse_tap_pipe.sv
// Bench for dsp_be_mlse_tap_pipe: directed scenarios plus random beats against a
// symbol-stream reference model (previous accepted beat concatenated with current).
module tb_dsp_be_mlse_tap_pipe;
    import dsp_be_mlse_tap_pipe_pkg::*;

    localparam int R = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    i_rst, i_vld, i_flush;
    flag_unit_t [R-1:0]      i_flag_unit;
    ari_unit_t  [R-1:0]      i_ari_unit;
    logic                    o_vld, o_hist_ok;
    flag_unit_t [R-1:0][2:0] o_flag;
    ari_unit_t  [R-1:0]      o_ari;

    dsp_be_mlse_tap_pipe #(.PRLL_RANK(R)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_vld              (i_vld),
        .i_flush            (i_flush),
        .i_flag_unit        (i_flag_unit),
        .i_ari_unit         (i_ari_unit),
        .o_vld              (o_vld),
        .o_flag_unit_d0m1m2 (o_flag),
        .o_ari_unit_dm2     (o_ari),
        .o_hist_ok          (o_hist_ok)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    flag_unit_t              last_f [R];
    ari_unit_t               last_a [R];
    bit                      have_last;
    logic                    e_vld, e_ok;
    flag_unit_t [R-1:0][2:0] e_flag;
    ari_unit_t  [R-1:0]      e_ari;

    task automatic model_step(input bit rst, input bit vld, input bit flush,
                              input flag_unit_t [R-1:0] f, input ari_unit_t [R-1:0] a);
        flag_unit_t sf [2*R];
        ari_unit_t  sa [2*R];
        if (rst || flush) begin
            if (rst) begin
                e_flag = '0;
                e_ari  = '0;
            end
            e_vld = 1'b0;
            e_ok  = 1'b0;
            have_last = 1'b0;
            for (int i = 0; i < R; i++) begin
                last_f[i] = '0;
                last_a[i] = '0;
            end
        end else if (vld) begin
            for (int i = 0; i < R; i++) begin
                sf[i] = last_f[i];  sf[R+i] = f[i];
                sa[i] = last_a[i];  sa[R+i] = a[i];
            end
            for (int k = 0; k < R; k++) begin
                e_flag[k][2] = sf[R+k];
                e_flag[k][1] = sf[R+k-1];
                e_flag[k][0] = sf[R+k-2];
                e_ari[k]     = sa[R+k-2];
            end
            e_vld = 1'b1;
            e_ok  = have_last;
            have_last = 1'b1;
            for (int i = 0; i < R; i++) begin
                last_f[i] = f[i];
                last_a[i] = a[i];
            end
        end else begin
            e_vld = 1'b0;
            e_ok  = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst, input bit vld, input bit flush,
                         input flag_unit_t [R-1:0] f, input ari_unit_t [R-1:0] a);
        i_rst = rst; i_vld = vld; i_flush = flush;
        i_flag_unit = f; i_ari_unit = a;
        @(posedge clk);
        model_step(rst, vld, flush, f, a);
        #1;
    endtask

    task automatic rand_beat(output flag_unit_t [R-1:0] f, output ari_unit_t [R-1:0] a);
        f = $urandom;
        a = {$urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        for (int c = 0; c < 3; c++) begin
            rand_beat(f, a);
            cycle(1'b1, 1'b1, 1'b0, f, a);
            n_cmp++;
            if (o_vld !== 1'b0 || o_hist_ok !== 1'b0 || o_flag !== '0 || o_ari !== '0) begin
                n_fail++;
                $display("FAIL reset: vld=%b ok=%b flag=%h ari=%h required all zero",
                         o_vld, o_hist_ok, o_flag, o_ari);
            end
        end
    endtask

    task automatic test_cold_start();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        f = '0; a = '0;
        f[3].p2   = 1'b1;
        a[2].dpst = 8'd1;
        cycle(1'b0, 1'b1, 1'b0, f, a);
        n_cmp++;
        if (o_vld !== 1'b1 || o_hist_ok !== 1'b0 || o_flag[0][1] !== '0 || o_flag[0][0] !== '0
            || o_flag[3][2].p2 !== 1'b1 || o_flag[1][0] !== '0) begin
            n_fail++;
            $display("FAIL cold_start: vld=%b ok=%b l0dm1=%h l0dm2=%h l3d0p2=%b l1dm2=%h required 1 0 0 0 1 0",
                     o_vld, o_hist_ok, o_flag[0][1], o_flag[0][0], o_flag[3][2].p2, o_flag[1][0]);
        end
        n_cmp++;
        if (o_flag !== e_flag || o_ari !== e_ari) begin
            n_fail++;
            $display("FAIL cold_start_full: flag=%h ari=%h required flag=%h ari=%h", o_flag, o_ari, e_flag, e_ari);
        end
    endtask

    task automatic test_cross_beat();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        f = '0; a = '0;
        f[3].p4p   = 1'b1;
        a[2].dcomp = 8'd1;
        cycle(1'b0, 1'b1, 1'b0, f, a);
        rand_beat(f, a);
        cycle(1'b0, 1'b1, 1'b0, f, a);
        n_cmp++;
        if (o_flag[0][1].p4p !== 1'b1 || o_ari[0].dcomp !== 8'd1 || o_hist_ok !== 1'b1 || o_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL cross_beat: l0dm1.p4p=%b l0ari.dcomp=%h ok=%b vld=%b required 1 01 1 1",
                     o_flag[0][1].p4p, o_ari[0].dcomp, o_hist_ok, o_vld);
        end
    endtask

    task automatic test_bubbles();
        flag_unit_t [R-1:0] fa, fb;
        ari_unit_t  [R-1:0] aa, ab;
        flag_unit_t [R-1:0][2:0] held_f;
        ari_unit_t  [R-1:0] held_a;
        rand_beat(fa, aa);
        cycle(1'b0, 1'b1, 1'b0, fa, aa);
        held_f = e_flag;
        held_a = e_ari;
        for (int c = 0; c < 3; c++) begin
            rand_beat(fb, ab);
            cycle(1'b0, 1'b0, 1'b0, fb, ab);
            n_cmp++;
            if (o_vld !== 1'b0 || o_flag !== held_f || o_ari !== held_a) begin
                n_fail++;
                $display("FAIL bubble_hold[%0d]: vld=%b flag=%h ari=%h required vld=0 flag=%h ari=%h",
                         c, o_vld, o_flag, o_ari, held_f, held_a);
            end
        end
        rand_beat(fb, ab);
        cycle(1'b0, 1'b1, 1'b0, fb, ab);
        n_cmp++;
        if (o_vld !== 1'b1 || o_flag[0][1] !== fa[3] || o_flag[0][0] !== fa[2] || o_ari[0] !== aa[2]
            || o_flag[1][0] !== fa[3] || o_ari[1] !== aa[3] || o_hist_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble_taps: vld=%b dm1=%h dm2=%h ari=%h ok=%b required 1 %h %h %h 1",
                     o_vld, o_flag[0][1], o_flag[0][0], o_ari[0], o_hist_ok, fa[3], fa[2], aa[2]);
        end
    endtask

    task automatic test_flush_race();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        flag_unit_t [R-1:0][2:0] held_f;
        ari_unit_t  [R-1:0] held_a;
        held_f = e_flag;
        held_a = e_ari;
        rand_beat(f, a);
        cycle(1'b0, 1'b1, 1'b1, f, a);
        n_cmp++;
        if (o_vld !== 1'b0 || o_flag !== held_f || o_ari !== held_a) begin
            n_fail++;
            $display("FAIL flush_drop: vld=%b flag=%h ari=%h required vld=0 flag=%h ari=%h",
                     o_vld, o_flag, o_ari, held_f, held_a);
        end
        rand_beat(f, a);
        cycle(1'b0, 1'b1, 1'b0, f, a);
        n_cmp++;
        if (o_vld !== 1'b1 || o_hist_ok !== 1'b0 || o_flag[0][1] !== '0 || o_flag[0][0] !== '0 || o_ari[0] !== '0) begin
            n_fail++;
            $display("FAIL flush_next: vld=%b ok=%b dm1=%h dm2=%h ari=%h required 1 0 0 0 0",
                     o_vld, o_hist_ok, o_flag[0][1], o_flag[0][0], o_ari[0]);
        end
    endtask

    task automatic test_reset_mid();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        rand_beat(f, a);
        f[3] = 8'hFF;
        a[3] = 24'hFFFFFF;
        cycle(1'b0, 1'b1, 1'b0, f, a);
        rand_beat(f, a);
        cycle(1'b1, 1'b1, 1'b0, f, a);
        n_cmp++;
        if (o_vld !== 1'b0 || o_hist_ok !== 1'b0 || o_flag !== '0 || o_ari !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: vld=%b ok=%b flag=%h ari=%h required all zero",
                     o_vld, o_hist_ok, o_flag, o_ari);
        end
        rand_beat(f, a);
        cycle(1'b0, 1'b1, 1'b0, f, a);
        n_cmp++;
        if (o_vld !== 1'b1 || o_hist_ok !== 1'b0 || o_flag[1][0] !== '0 || o_ari[1] !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_next: vld=%b ok=%b l1dm2=%h l1ari=%h required 1 0 0 0",
                     o_vld, o_hist_ok, o_flag[1][0], o_ari[1]);
        end
    endtask

    task automatic test_back_to_back();
        flag_unit_t [R-1:0] f;
        ari_unit_t  [R-1:0] a;
        for (int c = 0; c < 1000; c++) begin
            rand_beat(f, a);
            cycle(1'b0, 1'b1, 1'b0, f, a);
            n_cmp++;
            if (o_vld !== e_vld || o_hist_ok !== e_ok || o_flag !== e_flag || o_ari !== e_ari) begin
                n_fail++;
                $display("FAIL b2b_model[%0d]: vld=%b ok=%b flag=%h ari=%h required %b %b %h %h",
                         c, o_vld, o_hist_ok, o_flag, o_ari, e_vld, e_ok, e_flag, e_ari);
            end
            for (int k = 2; k < R; k++) begin
                n_cmp++;
                if (o_flag[k][2] !== f[k] || o_flag[k][1] !== f[k-1] || o_flag[k][0] !== f[k-2]
                    || o_ari[k] !== a[k-2]) begin
                    n_fail++;
                    $display("FAIL b2b_intra[%0d] lane %0d: d0=%h dm1=%h dm2=%h ari=%h required %h %h %h %h",
                             c, k, o_flag[k][2], o_flag[k][1], o_flag[k][0], o_ari[k], f[k], f[k-1], f[k-2], a[k-2]);
                end
            end
        end
    endtask

    initial begin
        have_last = 1'b0;
        e_vld = 1'b0; e_ok = 1'b0; e_flag = '0; e_ari = '0;
        for (int i = 0; i < R; i++) begin
            last_f[i] = '0;
            last_a[i] = '0;
        end
        i_rst = 1'b1; i_vld = 1'b0; i_flush = 1'b0;
        i_flag_unit = '0; i_ari_unit = '0;
        test_reset();
        test_cold_start();
        test_cross_beat();
        test_bubbles();
        test_flush_race();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
